// File: rtl/axis_pkg.sv
// axis_pkg: shared stream-mux definitions
// Contents: default tdata width and the packet-lock state encoding.
package axis_pkg;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry registered stream buffer (main + skid) with registered ready
// Ports:
//   aclk/aresetn        clock, synchronous active-low reset
//   i_valid/i_data      upstream beat offered (taken only while o_ready=1)
//   o_ready             registered "skid entry empty"
//   o_valid/o_data      main register contents
//   i_ready             downstream ready
module axis_skid_buffer
  import axis_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);
  logic         r_main_valid, r_skid_valid, r_ready;
  logic [W-1:0] r_main_data, r_skid_data;
  logic         w_acc, w_xfer, w_load;
  logic         w_main_valid_n, w_skid_valid_n;
  logic [W-1:0] w_main_data_n, w_skid_data_n;
  assign w_acc  = i_valid && r_ready;
  assign w_xfer = r_main_valid && i_ready;
  // main register can take a new beat only when nothing waits in skid
  assign w_load = !r_skid_valid && (w_xfer || !r_main_valid);
  always_comb begin
    w_main_valid_n = r_skid_valid ? 1'b1 : (w_load ? w_acc : r_main_valid);
    w_main_data_n  = (r_skid_valid && w_xfer) ? r_skid_data :
                     (w_load && w_acc) ? i_data : r_main_data;
    w_skid_valid_n = r_skid_valid ? !w_xfer : (!w_load && w_acc);
    w_skid_data_n  = (!r_skid_valid && !w_load && w_acc) ? i_data : r_skid_data;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_n;
      r_skid_valid <= w_skid_valid_n;
      r_main_data  <= w_main_data_n;
      r_skid_data  <= w_skid_data_n;
      r_ready      <= !w_skid_valid_n;
    end
  end
  assign o_ready = r_ready;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;
endmodule

// File: rtl/axi_mux.sv
// axi_mux: two-input packet-aware AXI-Stream mux with registered skid-buffer output
// Ports:
//   aclk/aresetn                     clock, synchronous active-low reset
//   s_axis_{tdata,tvalid,tlast}_0/1  upstream sources
//   sel                              requested source, honoured only between packets
//   m_axis_tready                    ready back to the active source
//   s_axis_tready                    ready from the downstream sink
//   m_axis_{tdata,tvalid,tlast}      downstream beat
module axi_mux
  import axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata_0,
  input  logic              s_axis_tvalid_0,
  input  logic              s_axis_tlast_0,
  input  logic [DATA_W-1:0] s_axis_tdata_1,
  input  logic              s_axis_tvalid_1,
  input  logic              s_axis_tlast_1,
  input  logic              sel,
  output logic              m_axis_tready,
  input  logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast
);
  state_e            r_state, w_state_n;
  logic              w_active, w_valid, w_last, w_accept;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W:0]   w_out;
  assign w_active = (r_state == IDLE) ? sel : (r_state == LOCK1);
  assign w_valid  = w_active ? s_axis_tvalid_1 : s_axis_tvalid_0;
  assign w_data   = w_active ? s_axis_tdata_1  : s_axis_tdata_0;
  assign w_last   = w_active ? s_axis_tlast_1  : s_axis_tlast_0;
  assign w_accept = w_valid && m_axis_tready;
  // a non-last beat locks onto the source that supplied it until its tlast is taken
  always_comb begin
    w_state_n = r_state;
    if (w_accept) w_state_n = w_last ? IDLE : (w_active ? LOCK1 : LOCK0);
  end
  always_ff @(posedge aclk) r_state <= !aresetn ? IDLE : w_state_n;
  axis_skid_buffer #(.W(DATA_W + 1)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_valid (w_valid),
    .i_data  ({w_last, w_data}),
    .o_ready (m_axis_tready),
    .o_valid (m_axis_tvalid),
    .o_data  (w_out),
    .i_ready (s_axis_tready)
  );
  assign m_axis_tlast = w_out[DATA_W];
  assign m_axis_tdata = w_out[DATA_W-1:0];
endmodule

// File: tb/tb_axi_mux.sv
// tb_axi_mux: randomized self-checking bench for axi_mux against a queue-based reference
module tb_axi_mux;
  localparam int W = 8;
  typedef logic [W:0] beat_t;
  logic         aclk = 1'b0, aresetn, sel;
  logic [W-1:0] s_axis_tdata_0, s_axis_tdata_1, m_axis_tdata;
  logic         s_axis_tvalid_0, s_axis_tvalid_1, s_axis_tlast_0, s_axis_tlast_1;
  logic         m_axis_tready, s_axis_tready, m_axis_tvalid, m_axis_tlast;
  beat_t        q[$];
  bit           rdy, mid, lsrc, acc_f, act_f;
  int           n_vec, n_err;
  always #5 aclk = ~aclk;
  axi_mux #(.DATA_W(W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata_0(s_axis_tdata_0), .s_axis_tvalid_0(s_axis_tvalid_0), .s_axis_tlast_0(s_axis_tlast_0),
    .s_axis_tdata_1(s_axis_tdata_1), .s_axis_tvalid_1(s_axis_tvalid_1), .s_axis_tlast_1(s_axis_tlast_1),
    .sel(sel), .m_axis_tready(m_axis_tready), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast)
  );
  // Reference: the output is a FIFO of at most two beats; upstream is ready whenever
  // fewer than two beats were held after the previous edge; a non-last beat locks its source.
  task automatic tick();
    bit    act, v;
    beat_t b;
    act   = mid ? lsrc : sel;
    v     = act ? s_axis_tvalid_1 : s_axis_tvalid_0;
    b     = act ? {s_axis_tlast_1, s_axis_tdata_1} : {s_axis_tlast_0, s_axis_tdata_0};
    acc_f = 1'b0;
    act_f = act;
    if (!aresetn) begin
      q.delete();
      rdy = 1'b0;
      mid = 1'b0;
    end else begin
      if (q.size() != 0 && s_axis_tready) void'(q.pop_front());
      if (v && rdy) begin
        acc_f = 1'b1;
        q.push_back(b);
        mid  = !b[W];
        lsrc = act;
      end
      rdy = q.size() < 2;
    end
    @(negedge aclk);
  endtask
  task automatic test_reset();
    aresetn = 1'b0;
    s_axis_tvalid_0 = 1'b1;
    s_axis_tvalid_1 = 1'b1;
    tick();
    n_vec += 4;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
    if (m_axis_tdata !== 8'h00) begin n_err++; $display("FAIL rst_tdata got %h want 00", m_axis_tdata); end
    if (m_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready got %b want 0", m_axis_tready); end
    s_axis_tvalid_0 = 1'b0;
    s_axis_tvalid_1 = 1'b0;
    aresetn = 1'b1;
    tick();
    n_vec += 2;
    if (m_axis_tready !== 1'b1) begin n_err++; $display("FAIL rel_tready got %b want 1", m_axis_tready); end
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rel_tvalid got %b want 0", m_axis_tvalid); end
  endtask
  task automatic test_pass();
    sel = 1'b0;
    s_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid_0 = 1'b1;
      s_axis_tdata_0  = 8'(i);
      s_axis_tlast_0  = (i == 7);
      tick();
      n_vec += 4;
      if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL pass_valid beat %0d got %b want 1", i, m_axis_tvalid); end
      if (m_axis_tdata !== 8'(i)) begin n_err++; $display("FAIL pass_data beat %0d got %h want %h", i, m_axis_tdata, 8'(i)); end
      if (m_axis_tlast !== (i == 7)) begin n_err++; $display("FAIL pass_last beat %0d got %b want %b", i, m_axis_tlast, i == 7); end
      if (m_axis_tready !== 1'b1) begin n_err++; $display("FAIL pass_ready beat %0d got %b want 1", i, m_axis_tready); end
    end
    s_axis_tvalid_0 = 1'b0;
    tick();
    n_vec++;
    if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL pass_drain got %b want 0", m_axis_tvalid); end
  endtask
  task automatic test_backpressure();
    beat_t rx[$];
    int    k = 0;
    bit    saw_low = 1'b0, stalled = 1'b0;
    beat_t prev = '0;
    sel = 1'b0;
    for (int c = 0; c < 40 && rx.size() < 8; c++) begin
      n_vec += 2;
      if (m_axis_tvalid !== (q.size() != 0)) begin n_err++; $display("FAIL bp_valid cyc %0d got %b want %b", c, m_axis_tvalid, q.size() != 0); end
      if (m_axis_tready !== rdy) begin n_err++; $display("FAIL bp_ready cyc %0d got %b want %b", c, m_axis_tready, rdy); end
      if (q.size() != 0) begin
        n_vec++;
        if ({m_axis_tlast, m_axis_tdata} !== q[0]) begin n_err++; $display("FAIL bp_data cyc %0d got %h want %h", c, {m_axis_tlast, m_axis_tdata}, q[0]); end
      end
      if (stalled) begin
        n_vec++;
        if ({m_axis_tlast, m_axis_tdata} !== prev) begin n_err++; $display("FAIL bp_hold cyc %0d got %h want %h", c, {m_axis_tlast, m_axis_tdata}, prev); end
      end
      if (!m_axis_tready) saw_low = 1'b1;
      s_axis_tready   = !(c >= 2 && c < 5);
      s_axis_tvalid_0 = k < 8;
      s_axis_tdata_0  = 8'(8'h10 + k);
      s_axis_tlast_0  = (k == 7);
      stalled = m_axis_tvalid && !s_axis_tready;
      prev    = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && s_axis_tready) rx.push_back({m_axis_tlast, m_axis_tdata});
      tick();
      if (acc_f) k++;
    end
    s_axis_tvalid_0 = 1'b0;
    s_axis_tready   = 1'b1;
    n_vec += 2;
    if (saw_low !== 1'b1) begin n_err++; $display("FAIL bp_ready_drop got %b want 1", saw_low); end
    if (rx.size() != 8) begin n_err++; $display("FAIL bp_count got %0d want 8", rx.size()); end
    for (int i = 0; i < rx.size(); i++) begin
      n_vec++;
      if (rx[i] !== {i == 7, 8'(8'h10 + i)}) begin n_err++; $display("FAIL bp_order idx %0d got %h want %h", i, rx[i], {i == 7, 8'(8'h10 + i)}); end
    end
  endtask
  task automatic test_sel_switch();
    beat_t rx[$];
    beat_t exp_q[$];
    int    k = 0;
    bit    done1 = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back({i == 5, 8'(8'h20 + i)});
    exp_q.push_back({1'b1, 8'h30});
    sel = 1'b0;
    s_axis_tready = 1'b1;
    s_axis_tvalid_1 = 1'b0;
    for (int c = 0; c < 40 && rx.size() < 7; c++) begin
      n_vec++;
      if (m_axis_tvalid !== (q.size() != 0)) begin n_err++; $display("FAIL sw_valid cyc %0d got %b want %b", c, m_axis_tvalid, q.size() != 0); end
      s_axis_tvalid_0 = k < 6;
      s_axis_tdata_0  = 8'(8'h20 + k);
      s_axis_tlast_0  = (k == 5);
      if (k >= 3) begin
        sel = 1'b1;
        s_axis_tvalid_1 = !done1;
        s_axis_tdata_1  = 8'h30;
        s_axis_tlast_1  = 1'b1;
      end
      if (m_axis_tvalid) rx.push_back({m_axis_tlast, m_axis_tdata});
      tick();
      if (acc_f && !act_f) k++;
      if (acc_f && act_f) done1 = 1'b1;
    end
    s_axis_tvalid_0 = 1'b0;
    s_axis_tvalid_1 = 1'b0;
    n_vec++;
    if (rx.size() != 7) begin n_err++; $display("FAIL sw_count got %0d want 7", rx.size()); end
    for (int i = 0; i < rx.size() && i < 7; i++) begin
      n_vec++;
      if (rx[i] !== exp_q[i]) begin n_err++; $display("FAIL sw_order idx %0d got %h want %h", i, rx[i], exp_q[i]); end
    end
    tick();
  endtask
  task automatic test_inactive();
    sel = 1'b1;
    s_axis_tready = 1'b1;
    s_axis_tvalid_1 = 1'b0;
    s_axis_tvalid_0 = 1'b1;
    s_axis_tdata_0  = 8'h55;
    s_axis_tlast_0  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL inact_valid cyc %0d got %b want 0", c, m_axis_tvalid); end
    end
    s_axis_tvalid_0 = 1'b0;
  endtask
  task automatic test_single_beat();
    s_axis_tready = 1'b1;
    s_axis_tvalid_0 = 1'b1;
    s_axis_tvalid_1 = 1'b1;
    s_axis_tlast_0  = 1'b1;
    s_axis_tlast_1  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = i[0];
      s_axis_tdata_0 = 8'(8'hA0 + i);
      s_axis_tdata_1 = 8'(8'hB0 + i);
      tick();
      n_vec += 3;
      if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL single_valid beat %0d got %b want 1", i, m_axis_tvalid); end
      if (m_axis_tdata !== 8'((i[0] ? 8'hB0 : 8'hA0) + i)) begin n_err++; $display("FAIL single_data beat %0d got %h want %h", i, m_axis_tdata, 8'((i[0] ? 8'hB0 : 8'hA0) + i)); end
      if (m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL single_last beat %0d got %b want 1", i, m_axis_tlast); end
    end
    s_axis_tvalid_0 = 1'b0;
    s_axis_tvalid_1 = 1'b0;
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      n_vec += 2;
      if (m_axis_tvalid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, m_axis_tvalid, q.size() != 0); end
      if (m_axis_tready !== rdy) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, m_axis_tready, rdy); end
      if (q.size() != 0) begin
        n_vec++;
        if ({m_axis_tlast, m_axis_tdata} !== q[0]) begin n_err++; $display("FAIL rnd_data cyc %0d got %h want %h", c, {m_axis_tlast, m_axis_tdata}, q[0]); end
      end
      aresetn       = $urandom_range(0, 149) != 0;
      sel           = 1'($urandom);
      s_axis_tready = $urandom_range(0, 3) != 0;
      if (!s_axis_tvalid_0 && $urandom_range(0, 1) == 1) begin
        s_axis_tvalid_0 = 1'b1;
        s_axis_tdata_0  = 8'($urandom);
        s_axis_tlast_0  = $urandom_range(0, 3) == 0;
      end
      if (!s_axis_tvalid_1 && $urandom_range(0, 1) == 1) begin
        s_axis_tvalid_1 = 1'b1;
        s_axis_tdata_1  = 8'($urandom);
        s_axis_tlast_1  = $urandom_range(0, 3) == 0;
      end
      tick();
      if (acc_f && !act_f) s_axis_tvalid_0 = 1'b0;
      if (acc_f && act_f) s_axis_tvalid_1 = 1'b0;
    end
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    aresetn = 1'b0;
    sel = 1'b0;
    s_axis_tready = 1'b1;
    s_axis_tdata_0 = '0;
    s_axis_tdata_1 = '0;
    s_axis_tvalid_0 = 1'b0;
    s_axis_tvalid_1 = 1'b0;
    s_axis_tlast_0 = 1'b0;
    s_axis_tlast_1 = 1'b0;
    @(negedge aclk);
    test_reset();
    test_pass();
    test_backpressure();
    test_sel_switch();
    test_inactive();
    test_single_beat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_mux.md
# axi_mux

Two-input, packet-aware AXI-Stream multiplexer with a registered output stage. It forwards 8-bit beats from one of two upstream AXIS sources, chosen by `sel`, to a single downstream sink. Selection changes only at packet boundaries (`tlast`), so packets never interleave. The block sits between stream producers and a shared consumer, such as a DMA or a serializer.

## Interface
Parameters:
- `DATA_W`, 8: tdata width.

Ports:
- `aclk` input 1: single clock; all logic on the rising edge.
- `aresetn` input 1: reset, synchronous, active-low.
- `s_axis_tdata_0` input DATA_W: source 0 data.
- `s_axis_tvalid_0` input 1: source 0 valid.
- `s_axis_tlast_0` input 1: source 0 end of packet.
- `s_axis_tdata_1` input DATA_W: source 1 data.
- `s_axis_tvalid_1` input 1: source 1 valid.
- `s_axis_tlast_1` input 1: source 1 end of packet.
- `sel` input 1: requested source (0 or 1).
- `m_axis_tready` output 1: ready returned to the upstream sources. Only the currently active source may treat it as a handshake.
- `s_axis_tready` input 1: ready from the downstream sink.
- `m_axis_tdata` output DATA_W: output data.
- `m_axis_tvalid` output 1: output valid.
- `m_axis_tlast` output 1: output end of packet.

## Operation
- Active source:
  - State `IDLE`: active = `sel`.
  - State `LOCK0`: active = 0.
  - State `LOCK1`: active = 1.
- Upstream accept: fires when `s_axis_tvalid_<active> && m_axis_tready`. Beats on the inactive source are never accepted. The inactive source must hold its data.
- State transitions, evaluated on each accepted beat:
  - `IDLE` with tlast=0 goes to `LOCK<active>`.
  - `IDLE` with tlast=1 stays in `IDLE` (single-beat packet).
  - `LOCKx` with tlast=1 goes to `IDLE`.
  - `LOCKx` with tlast=0 stays in `LOCKx`.
  - No accept: state holds.
  - `sel` is ignored in the `LOCK` states.
- Output stage is a 2-entry skid buffer: a main register plus a skid register.
  - `m_axis_tready` is a registered signal, equal to "skid register empty".
  - When the sink stalls, an accepted beat lands in the skid register. `m_axis_tready` then drops the following cycle.
- Downstream transfer fires when `m_axis_tvalid && s_axis_tready`.
  - On transfer, the skid entry, if present, moves to the main register.
  - Otherwise the new accepted beat, if any, loads the main register.
- Data, tlast and order are preserved exactly. No beat is dropped or duplicated.
- `m_axis_tdata` and `m_axis_tlast` hold steady while `m_axis_tvalid && !s_axis_tready`.

## Timing
- Reset (`aresetn`=0 at a rising edge):
  - `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tdata` = 0.
  - `m_axis_tready` = 0.
  - State = `IDLE`; both buffer entries empty.
- The first edge with `aresetn`=1 sets `m_axis_tready`=1.
- Latency: an accepted beat appears on `m_axis_*` one cycle after acceptance when the main register is empty or transferring.
- Throughput: 1 beat/cycle when the sink holds `s_axis_tready`=1.
- Simultaneous accept and transfer with the skid register empty: the main register reloads in the same edge, with no bubble.
- Sink stall:
  - At most one extra beat is accepted, into the skid register.
  - `m_axis_tready`=0 from the next cycle until the skid register drains.
- `sel` toggling mid-packet has no effect until tlast is accepted. A new `sel` value applies to the beat accepted in the first `IDLE` cycle.
- Reset asserted mid-packet: in-flight beats are discarded and the lock is cleared.

## Structure
- Shared package `axis_pkg`: `DATA_W` default, and the state enum (`IDLE`, `LOCK0`, `LOCK1`).
- Natural sub-module: `axis_skid_buffer`, carrying `{tlast, tdata}`. It provides the registered ready output and the main/skid registers.
- Top level: state machine, input mux, and accept logic.

## Test plan
- Reset: hold `aresetn`=0 for one edge. Check all outputs are 0. Check `m_axis_tready`=1 one edge after release.
- Pass-through: `sel`=0, `s_axis_tready`=1, source 0 streams 8 beats 0x00..0x07 with tlast on beat 7. Output shows the identical sequence, each beat one cycle later, with `m_axis_tlast` on 0x07.
- Backpressure: while streaming, drop `s_axis_tready` for 3 cycles.
  - Check `m_axis_tready` falls after one skid beat.
  - Check the output holds its data and tlast while stalled.
  - After release, check no loss or duplication: 8 of 8 beats in order.
- Mid-packet `sel` change: start a source-0 packet, set `sel`=1 at beat 3 with `s_axis_tvalid_1`=1.
  - Check source 0 finishes through its tlast.
  - Check the first source-1 beat follows with no interleaving.
- Inactive source ignored: `sel`=1 and `s_axis_tvalid_1`=0 while `s_axis_tvalid_0`=1. Check `m_axis_tvalid` stays 0.
- Single-beat packets: alternate `sel` every cycle, with tlast=1 on every beat of both sources. Check output beats alternate 0,1,0,1 by source.
